// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the data-memory responder.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: access-size encodings, responder state enum, byte-enable and
// lane-shift helpers used by dmem_responder.
package mem_if_pkg;

  localparam int DMEM_DATA_W    = 64;
  localparam int BYTES_PER_WORD = DMEM_DATA_W / 8;

  typedef enum logic [2:0] {
    BYTE                 = 3'd0,
    HALF_WORD            = 3'd1,
    WORD                 = 3'd2,
    DOUBLE_WORD          = 3'd3,
    UNSIGNED_BYTE        = 3'd4,
    UNSIGNED_HALF_WORD   = 3'd5,
    UNSIGNED_WORD        = 3'd6,
    UNSIGNED_DOUBLE_WORD = 3'd7
  } mem_size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_WAIT,
    ST_READ_RESP,
    ST_WRITE_WAIT,
    ST_WRITE_DONE,
    ST_RECOVER
  } dmem_state_e;

  // Byte mask before truncation to the word: [7:0] are the in-word enables,
  // any bit set in [15:8] means the access ran past the 8-byte boundary.
  function automatic logic [15:0] be_wide(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] m;
    case (size)
      2'd0:    m = 16'h0001;
      2'd1:    m = 16'h0003;
      2'd2:    m = 16'h000F;
      default: m = 16'h00FF;
    endcase
    return m << off;
  endfunction

  function automatic logic [DMEM_DATA_W-1:0] wdata_align(input logic [DMEM_DATA_W-1:0] d,
                                                         input logic [2:0] off);
    return d << {off, 3'b000};
  endfunction

  // Zero-fills from the top so the addressed byte lands in [7:0].
  function automatic logic [DMEM_DATA_W-1:0] rdata_align(input logic [DMEM_DATA_W-1:0] d,
                                                         input logic [2:0] off);
    return d >> {off, 3'b000};
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage (master) and responder (slave).
// Latency: n/a (wires only).
// Backpressure: writes gated by S_W_READY; reads held by the master until S_R_DATA_VALID.
// Signals: S_R_ADDR/S_R_ADDR_VALID -> S_R_DATA/S_R_DATA_VALID read path,
// S_W_VALID/ADDR/DATA/SIZE -> S_W_READY/S_W_COMPLETE write path, misalign_err flag.
interface dmem_responder_if
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = DMEM_DATA_W
);
  logic [ADDR_WIDTH-1:0] S_R_ADDR;
  logic                  S_R_ADDR_VALID;
  logic [DATA_WIDTH-1:0] S_R_DATA;
  logic                  S_R_DATA_VALID;
  logic                  S_W_VALID;
  logic [ADDR_WIDTH-1:0] S_W_ADDR;
  logic [DATA_WIDTH-1:0] S_W_DATA;
  logic [3:0]            S_W_SIZE;
  logic                  S_W_READY;
  logic                  S_W_COMPLETE;
  logic                  misalign_err;

  modport master (
    output S_R_ADDR, S_R_ADDR_VALID, S_W_VALID, S_W_ADDR, S_W_DATA, S_W_SIZE,
    input  S_R_DATA, S_R_DATA_VALID, S_W_READY, S_W_COMPLETE, misalign_err
  );

  modport slave (
    input  S_R_ADDR, S_R_ADDR_VALID, S_W_VALID, S_W_ADDR, S_W_DATA, S_W_SIZE,
    output S_R_DATA, S_R_DATA_VALID, S_W_READY, S_W_COMPLETE, misalign_err
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port doubleword store with per-byte write enables.
// Latency: combinational read of i_idx; write lands on the rising edge.
// Backpressure: none; the caller sequences access.
// Ports: clk, i_idx word index, i_we/i_be/i_wdata write side, o_rdata read word.
module dmem_array
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IW          = $clog2(DEPTH_WORDS)
) (
  input  logic                   clk,
  input  logic [IW-1:0]          i_idx,
  input  logic                   i_we,
  input  logic [7:0]             i_be,
  input  logic [DMEM_DATA_W-1:0] i_wdata,
  output logic [DMEM_DATA_W-1:0] o_rdata
);

  logic [DMEM_DATA_W-1:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: fixed-latency reads/writes into a local doubleword array.
// Latency: read valid READ_LATENCY cycles after capture, write complete WRITE_LATENCY after.
// Backpressure: S_W_READY only in IDLE; reads held by initiator; one transaction in flight.
// Ports: clk, reset (async active-low), bus (dmem_responder_if.slave).
module dmem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int DEPTH_WORDS   = 1024,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input logic              clk,
  input logic              reset,
  dmem_responder_if.slave  bus
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = 8;

  dmem_state_e           r_state;
  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [1:0]            r_size;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvld;
  logic                  r_wcomp;
  logic                  r_mis;

  logic                  w_ready;
  logic [15:0]           w_be_wide;
  logic                  w_cross;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_we;
  logic                  w_unused;

  // Reads and writes share one captured address, so the array index is
  // always taken from r_addr; bits above the array span simply wrap.
  assign w_be_wide = be_wide(r_size, r_addr[2:0]);
  assign w_cross   = |w_be_wide[15:8];
  assign w_we      = (r_state == ST_WRITE_DONE);
  assign w_ready   = (r_state == ST_IDLE) && reset;
  assign w_unused  = ^{r_addr[ADDR_WIDTH-1:3+IW], bus.S_W_SIZE[3:2]};

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IW(IW)) u_array (
    .clk     (clk),
    .i_idx   (r_addr[3 +: IW]),
    .i_we    (w_we),
    .i_be    (w_be_wide[7:0]),
    .i_wdata (wdata_align(r_wdata, r_addr[2:0])),
    .o_rdata (w_word)
  );

  // Responses are registered on the edge leaving READ_RESP/WRITE_DONE, so the
  // pulses are visible during RECOVER, which is also when the initiator drops
  // its valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_rdata <= '0;
      r_rvld  <= 1'b0;
      r_wcomp <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_rvld  <= 1'b0;
      r_wcomp <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.S_R_ADDR_VALID) begin
            r_addr  <= bus.S_R_ADDR;
            r_cnt   <= CW'(READ_LATENCY - 1);
            r_state <= (READ_LATENCY == 1) ? ST_READ_RESP : ST_READ_WAIT;
          end else if (bus.S_W_VALID && w_ready) begin
            r_addr  <= bus.S_W_ADDR;
            r_wdata <= bus.S_W_DATA;
            r_size  <= bus.S_W_SIZE[1:0];
            r_cnt   <= CW'(WRITE_LATENCY - 1);
            r_state <= (WRITE_LATENCY == 1) ? ST_WRITE_DONE : ST_WRITE_WAIT;
          end
        end
        ST_READ_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= ST_READ_RESP;
        end
        ST_WRITE_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= ST_WRITE_DONE;
        end
        ST_READ_RESP: begin
          r_rdata <= rdata_align(w_word, r_addr[2:0]);
          r_rvld  <= 1'b1;
          r_state <= ST_RECOVER;
        end
        ST_WRITE_DONE: begin
          r_wcomp <= 1'b1;
          if (w_cross) r_mis <= 1'b1;
          r_state <= ST_RECOVER;
        end
        ST_RECOVER: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.S_R_DATA       = r_rdata;
  assign bus.S_R_DATA_VALID = r_rvld;
  assign bus.S_W_READY      = w_ready;
  assign bus.S_W_COMPLETE   = r_wcomp;
  assign bus.misalign_err   = r_mis;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder with a byte-level reference memory.
// Latency: checks READ_LATENCY=2 / WRITE_LATENCY=1 response timing.
// Backpressure: exercises read priority, S_W_READY gating and back-to-back reads.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

  dmem_responder #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .DEPTH_WORDS(1024),
    .READ_LATENCY(2), .WRITE_LATENCY(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  mb [8192];
  logic        exp_mis = 1'b0;
  logic [63:0] exp_q [$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_read(input logic [63:0] a);
    logic [63:0] r = '0;
    int base = int'(a[12:3]) * 8;
    int off  = int'(a[2:0]);
    for (int k = 0; k < 8; k++) if (off + k < 8) r[8*k +: 8] = mb[base + off + k];
    return r;
  endfunction

  task automatic model_write(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz);
    int base = int'(a[12:3]) * 8;
    int off  = int'(a[2:0]);
    int n    = 1 << sz;
    for (int k = 0; k < n; k++) if (off + k < 8) mb[base + off + k] = d[8*k +: 8];
    if (off + n > 8) exp_mis = 1'b1;
  endtask

  task automatic do_read(input logic [63:0] a, output logic [63:0] d, output int lat);
    tick();
    bus.S_R_ADDR = a;
    bus.S_R_ADDR_VALID = 1'b1;
    lat = -1;
    d = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.S_R_DATA_VALID) begin
        lat = k - 1;
        d = bus.S_R_DATA;
        break;
      end
    end
    bus.S_R_ADDR_VALID = 1'b0;
  endtask

  task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz,
                          output int lat);
    tick();
    model_write(a, d, sz);
    bus.S_W_ADDR = a;
    bus.S_W_DATA = d;
    bus.S_W_SIZE = {2'b00, sz};
    bus.S_W_VALID = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.S_W_COMPLETE) begin
        lat = k - 1;
        break;
      end
    end
    bus.S_W_VALID = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.S_R_ADDR = '0; bus.S_R_ADDR_VALID = 1'b0;
    bus.S_W_VALID = 1'b0; bus.S_W_ADDR = '0; bus.S_W_DATA = '0; bus.S_W_SIZE = '0;
    for (int i = 0; i < 8192; i++) mb[i] = 8'h00;
    tick(); tick();
    n_cmp++; if (bus.S_R_DATA !== 64'h0) begin n_bad++; $display("FAIL rst_rdata got=%h want=0", bus.S_R_DATA); end
    n_cmp++; if (bus.S_R_DATA_VALID !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid got=%b want=0", bus.S_R_DATA_VALID); end
    n_cmp++; if (bus.S_W_COMPLETE !== 1'b0) begin n_bad++; $display("FAIL rst_wcomp got=%b want=0", bus.S_W_COMPLETE); end
    n_cmp++; if (bus.misalign_err !== 1'b0) begin n_bad++; $display("FAIL rst_mis got=%b want=0", bus.misalign_err); end
    n_cmp++; if (bus.S_W_READY !== 1'b0) begin n_bad++; $display("FAIL rst_wready got=%b want=0", bus.S_W_READY); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.S_W_READY !== 1'b1) begin n_bad++; $display("FAIL rst_release_wready got=%b want=1", bus.S_W_READY); end
  endtask

  task automatic test_write_read();
    logic [63:0] d, held;
    int lat;
    do_write(64'h100, 64'h1122334455667788, 2'd3, lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL wr_latency got=%0d want=1", lat); end
    tick();
    n_cmp++; if (bus.S_W_COMPLETE !== 1'b0) begin n_bad++; $display("FAIL wcomp_pulse got=%b want=0", bus.S_W_COMPLETE); end
    exp_q.push_back(model_read(64'h100));
    do_read(64'h100, d, lat);
    held = exp_q.pop_front();
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rd_latency got=%0d want=2", lat); end
    n_cmp++; if (d !== held) begin n_bad++; $display("FAIL rd_full got=%h want=%h", d, held); end
    tick();
    n_cmp++; if (bus.S_R_DATA_VALID !== 1'b0) begin n_bad++; $display("FAIL rvalid_pulse got=%b want=0", bus.S_R_DATA_VALID); end
    n_cmp++; if (bus.S_R_DATA !== held) begin n_bad++; $display("FAIL rdata_hold got=%h want=%h", bus.S_R_DATA, held); end
  endtask

  task automatic test_byte_write();
    logic [63:0] d, e;
    int lat;
    do_write(64'h103, 64'h00000000000000AB, 2'd0, lat);
    exp_q.push_back(model_read(64'h100));
    exp_q.push_back(model_read(64'h104));
    do_read(64'h100, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL byte_rd100 got=%h want=%h", d, e); end
    do_read(64'h104, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL byte_rd104 got=%h want=%h", d, e); end
    n_cmp++; if (bus.misalign_err !== 1'b0) begin n_bad++; $display("FAIL aligned_mis got=%b want=0", bus.misalign_err); end
  endtask

  task automatic test_priority();
    logic [63:0] d, e;
    int lat, rd_k = 0, wr_k = 0, rdy_bad = 0;
    logic rdy_after = 1'b0;
    tick();
    exp_q.push_back(model_read(64'h100));
    bus.S_R_ADDR = 64'h100; bus.S_R_ADDR_VALID = 1'b1;
    bus.S_W_ADDR = 64'h108; bus.S_W_DATA = 64'h0102030405060708; bus.S_W_SIZE = 4'd3;
    bus.S_W_VALID = 1'b1;
    model_write(64'h108, 64'h0102030405060708, 2'd3);
    d = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (rd_k == 0 && bus.S_W_READY !== 1'b0) rdy_bad++;
      if (bus.S_R_DATA_VALID) begin
        rd_k = k; d = bus.S_R_DATA;
        if (bus.S_W_READY !== 1'b0) rdy_bad++;
        bus.S_R_ADDR_VALID = 1'b0;
      end
      if (rd_k != 0 && k == rd_k + 1) rdy_after = bus.S_W_READY;
      if (bus.S_W_COMPLETE) begin
        wr_k = k;
        bus.S_W_VALID = 1'b0;
        break;
      end
    end
    bus.S_R_ADDR_VALID = 1'b0; bus.S_W_VALID = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if (rd_k !== 3) begin n_bad++; $display("FAIL prio_rd_cycle got=%0d want=3", rd_k); end
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL prio_rd_data got=%h want=%h", d, e); end
    n_cmp++; if (rdy_bad !== 0) begin n_bad++; $display("FAIL prio_wready_low got=%0d high cycles want=0", rdy_bad); end
    n_cmp++; if (rdy_after !== 1'b1) begin n_bad++; $display("FAIL prio_wready_idle got=%b want=1", rdy_after); end
    n_cmp++; if (wr_k !== 6) begin n_bad++; $display("FAIL prio_wr_cycle got=%0d want=6", wr_k); end
    exp_q.push_back(model_read(64'h108));
    do_read(64'h108, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL prio_wr_data got=%h want=%h", d, e); end
  endtask

  task automatic test_misalign();
    logic [63:0] d, e;
    int lat;
    do_write(64'h106, 64'h00000000DEADBEEF, 2'd2, lat);
    n_cmp++; if (bus.misalign_err !== exp_mis) begin n_bad++; $display("FAIL mis_set got=%b want=%b", bus.misalign_err, exp_mis); end
    exp_q.push_back(model_read(64'h100));
    do_read(64'h100, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL mis_data got=%h want=%h", d, e); end
    do_write(64'h110, 64'h5555AAAA5555AAAA, 2'd3, lat);
    n_cmp++; if (bus.misalign_err !== exp_mis) begin n_bad++; $display("FAIL mis_sticky got=%b want=%b", bus.misalign_err, exp_mis); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d, e;
    int lat, pulses = 0;
    do_write(64'h200, 64'hCAFEF00D12345678, 2'd3, lat);
    tick();
    bus.S_R_ADDR = 64'h200; bus.S_R_ADDR_VALID = 1'b1;
    tick();
    bus.S_R_ADDR_VALID = 1'b0;
    reset = 1'b0;
    exp_mis = 1'b0;
    #1;
    n_cmp++; if (bus.S_R_DATA !== 64'h0) begin n_bad++; $display("FAIL midrst_rdata got=%h want=0", bus.S_R_DATA); end
    n_cmp++; if (bus.misalign_err !== 1'b0) begin n_bad++; $display("FAIL midrst_mis got=%b want=0", bus.misalign_err); end
    n_cmp++; if (bus.S_W_READY !== 1'b0) begin n_bad++; $display("FAIL midrst_wready got=%b want=0", bus.S_W_READY); end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.S_R_DATA_VALID) pulses++;
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.S_R_DATA_VALID) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL midrst_no_pulse got=%0d want=0", pulses); end
    n_cmp++; if (bus.S_W_READY !== 1'b1) begin n_bad++; $display("FAIL midrst_idle got=%b want=1", bus.S_W_READY); end
    // A captured but uncommitted write is abandoned by reset.
    bus.S_W_ADDR = 64'h200; bus.S_W_DATA = 64'h0BADBADBADBADBAD; bus.S_W_SIZE = 4'd3;
    bus.S_W_VALID = 1'b1;
    tick();
    bus.S_W_VALID = 1'b0;
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.S_W_COMPLETE !== 1'b0) begin n_bad++; $display("FAIL midrst_wcomp got=%b want=0", bus.S_W_COMPLETE); end
    tick();
    reset = 1'b1;
    exp_q.push_back(model_read(64'h200));
    do_read(64'h200, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL midrst_keep got=%h want=%h", d, e); end
  endtask

  task automatic test_wrap();
    logic [63:0] d, e;
    int lat;
    do_write(64'h2000, 64'h0F1E2D3C4B5A6978, 2'd3, lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL wrap_wr_lat got=%0d want=1", lat); end
    exp_q.push_back(model_read(64'h0));
    do_read(64'h0, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL wrap_data got=%h want=%h", d, e); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    int p1 = 0, p2 = 0;
    tick();
    exp_q.push_back(model_read(64'h100));
    exp_q.push_back(model_read(64'h200));
    bus.S_R_ADDR = 64'h100; bus.S_R_ADDR_VALID = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 1) bus.S_R_ADDR = 64'h108;
      if (bus.S_R_DATA_VALID) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.S_R_DATA !== e) begin n_bad++; $display("FAIL b2b_data got=%h want=%h", bus.S_R_DATA, e); end
        if (p1 == 0) begin
          p1 = k;
          bus.S_R_ADDR = 64'h200;
        end else begin
          p2 = k;
          break;
        end
      end
    end
    bus.S_R_ADDR_VALID = 1'b0;
    n_cmp++; if (p2 - p1 !== 4) begin n_bad++; $display("FAIL b2b_spacing got=%0d want=4", p2 - p1); end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL b2b_leftover got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_random();
    logic [63:0] d, e, a;
    int lat;
    for (int w = 0; w < 4; w++) do_write(64'h300 + 64'(8 * w), {$urandom, $urandom}, 2'd3, lat);
    for (int i = 0; i < 6; i++) begin
      a = 64'h300 + 64'(8 * $urandom_range(0, 3)) + 64'($urandom_range(0, 7));
      do_write(a, {$urandom, $urandom}, 2'($urandom_range(0, 3)), lat);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL rnd_wr_lat got=%0d want=1", lat); end
      a = 64'h300 + 64'(8 * $urandom_range(0, 3)) + 64'($urandom_range(0, 7));
      exp_q.push_back(model_read(a));
      do_read(a, d, lat);
      e = exp_q.pop_front();
      n_cmp++; if (d !== e) begin n_bad++; $display("FAIL rnd_rd addr=%h got=%h want=%h", a, d, e); end
    end
    n_cmp++; if (bus.misalign_err !== exp_mis) begin n_bad++; $display("FAIL rnd_mis got=%b want=%b", bus.misalign_err, exp_mis); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_write();
    test_priority();
    test_misalign();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
